coin_key_debounce: RTL and testbench

Two-channel push-button conditioner for the coin-insertion keys of the cola vending controller. It sits directly upstream of the vending FSM: it takes the raw, bouncing, asynchronous active-low board keys and produces clean single-cycle insertion pulses. Pulses on the two channels never coincide, so the FSM never sees a 1-yuan and a 0.5-yuan coin in the same cycle.

---
 rtl/coin_key_pkg.sv | 19 +
 rtl/coin_key_debounce_if.sv | 9 +
 rtl/key_debounce_ch.sv | 117 +++++++++++
 rtl/coin_key_debounce.sv | 73 +++++++
 tb/tb_coin_key_debounce.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coin_key_pkg.sv
// rtl/coin_key_pkg.sv - shared types and constants for the coin key conditioner
package coin_key_pkg;

    localparam int CNT_W       = 32;
    localparam int KEY_1YUAN   = 0;
    localparam int KEY_0_5YUAN = 1;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CNT   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CNT = 2'd3
    } ch_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/coin_key_debounce_if.sv
// rtl/coin_key_debounce_if.sv - raw key inputs and conditioned pulse/level outputs
interface coin_key_debounce_if;
    logic [1:0] key;
    logic [1:0] key_flag;
    logic [1:0] key_level;

    modport master (output key, input key_flag, input key_level);
    modport slave  (input key, output key_flag, output key_level);
endinterface

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchronizer, debounce FSM, auto-repeat under KEY_REPEAT_EN
module key_debounce_ch
    import coin_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic req,
    output logic level
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 4 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("coin key debounce: invalid cycle parameters");
    end

    logic            sync1, sync2;
    ch_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic            req_nxt;
    logic            rpt_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASED;
            cnt   <= '0;
            req   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            req   <= req_nxt;
        end
    end

    // level drops on the qualifying edge itself, so the registered output
    // leaves HELD one cycle sooner than it enters it
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        req_nxt   = rpt_fire;
        level     = 1'b0;
        case (state)
            RELEASED: begin
                if (!sync2) state_nxt = PRESS_CNT;
            end
            PRESS_CNT: begin
                if (sync2) begin
                    state_nxt = RELEASED;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = HELD;
                    req_nxt   = 1'b1;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            HELD: begin
                level = 1'b1;
                if (sync2) state_nxt = RELEASE_CNT;
            end
            RELEASE_CNT: begin
                if (!sync2) begin
                    state_nxt = HELD;
                    level     = 1'b1;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = RELEASED;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                    level   = 1'b1;
                end
            end
            default: state_nxt = RELEASED;
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             repeating;

    assign rpt_fire = (state == HELD) && !sync2 &&
                      (hold_cnt == (repeating ? REPEAT_LAST : HOLD_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (state != HELD || sync2) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (rpt_fire) begin
            hold_cnt  <= '0;
            repeating <= 1'b1;
        end else begin
            hold_cnt  <= sat_inc(hold_cnt);
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/coin_key_debounce.sv
// rtl/coin_key_debounce.sv - two-channel coin key conditioner with non-coinciding pulses (KEY_REPEAT_EN adds auto-repeat)
module coin_key_debounce
    import coin_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    coin_key_debounce_if.slave   keys
);
    logic [1:0] req, lvl, cand;
    logic [1:0] pend, pend_nxt, flag_nxt;
    logic [1:0] key_flag_q, key_level_q;

    key_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch_1yuan (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (keys.key[KEY_1YUAN]),
        .req   (req[KEY_1YUAN]),
        .level (lvl[KEY_1YUAN])
    );

    key_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch_0_5yuan (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (keys.key[KEY_0_5YUAN]),
        .req   (req[KEY_0_5YUAN]),
        .level (lvl[KEY_0_5YUAN])
    );

    // a waiting 0.5-yuan request beats any fresh 1-yuan request
    always_comb begin
        flag_nxt = 2'b00;
        pend_nxt = 2'b00;
        cand     = req | pend;
        if (pend[KEY_0_5YUAN]) begin
            flag_nxt[KEY_0_5YUAN] = 1'b1;
            pend_nxt[KEY_1YUAN]   = cand[KEY_1YUAN];
            pend_nxt[KEY_0_5YUAN] = req[KEY_0_5YUAN];
        end else if (cand[KEY_1YUAN]) begin
            flag_nxt[KEY_1YUAN]   = 1'b1;
            pend_nxt[KEY_0_5YUAN] = cand[KEY_0_5YUAN];
        end else if (cand[KEY_0_5YUAN]) begin
            flag_nxt[KEY_0_5YUAN] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= 2'b00;
            key_flag_q  <= 2'b00;
            key_level_q <= 2'b00;
        end else begin
            pend        <= pend_nxt;
            key_flag_q  <= flag_nxt;
            key_level_q <= lvl;
        end
    end

    assign keys.key_flag  = key_flag_q;
    assign keys.key_level = key_level_q;

endmodule

// File: tb/tb_coin_key_debounce.sv
// tb/tb_coin_key_debounce.sv - self-checking bench for coin_key_debounce
module tb_coin_key_debounce;
    localparam int D = 8;
    localparam int H = 40;
    localparam int R = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    coin_key_debounce_if kif ();

    coin_key_debounce #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .keys  (kif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: a key is taken as pressed/released once its synchronized
    // sample has disagreed with the current level for D+1 consecutive edges.
    logic [1:0] m_h1, m_h2, m_lvl, m_req, m_pend, exp_flag, exp_level;
    int         m_run [2];
    int         m_age [2];
    logic [1:0] n_lvl, n_req, n_pend, n_flag, waiting;
    int         n_run [2];
    int         n_age [2];

    always_comb begin
        n_flag  = 2'b00;
        n_pend  = 2'b00;
        waiting = m_req | m_pend;
        if (m_pend[1]) begin
            n_flag = 2'b10;
            n_pend = {m_req[1], waiting[0]};
        end else if (waiting[0]) begin
            n_flag = 2'b01;
            n_pend = {waiting[1], 1'b0};
        end else if (waiting[1]) begin
            n_flag = 2'b10;
        end
        n_lvl = m_lvl;
        n_req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            n_run[i] = 0;
            n_age[i] = 0;
            if (!m_h2[i] != m_lvl[i]) begin
                n_run[i] = m_run[i] + 1;
                if (n_run[i] == D + 1) begin
                    n_lvl[i] = !m_h2[i];
                    n_req[i] = !m_h2[i];
                    n_run[i] = 0;
                end
            end else if (m_lvl[i] && m_run[i] == 0) begin
                n_age[i] = m_age[i] + 1;
`ifdef KEY_REPEAT_EN
                if (n_age[i] == H || (n_age[i] > H && (n_age[i] - H) % R == 0)) n_req[i] = 1'b1;
`endif
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h1 <= 2'b11; m_h2 <= 2'b11; m_lvl <= 2'b00; m_req <= 2'b00;
            m_pend <= 2'b00; exp_flag <= 2'b00; exp_level <= 2'b00;
            for (int i = 0; i < 2; i++) begin m_run[i] <= 0; m_age[i] <= 0; end
        end else begin
            m_h1 <= kif.key; m_h2 <= m_h1;
            m_lvl <= n_lvl; m_req <= n_req; m_pend <= n_pend;
            exp_flag <= n_flag; exp_level <= m_lvl & n_lvl;
            for (int i = 0; i < 2; i++) begin m_run[i] <= n_run[i]; m_age[i] <= n_age[i]; end
        end
    end

    task automatic test_reset();
        kif.key = 2'b11;
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (kif.key_flag !== 2'b00 || kif.key_level !== 2'b00) begin
                failures++;
                $display("FAIL reset flag=%b level=%b required 00/00", kif.key_flag, kif.key_level);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        int e = 0, first = -1, npulse = 0, fall = -1;
        logic prev = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (c == 0) e = cyc + 1;
            kif.key = (c < 30) ? 2'b10 : 2'b11;
            @(negedge clk);
            checks++;
            if (kif.key_flag !== exp_flag || kif.key_level !== exp_level) begin
                failures++;
                $display("FAIL clean_press_model cyc=%0d flag=%b/%b level=%b/%b", cyc, kif.key_flag, exp_flag, kif.key_level, exp_level);
            end
            if (kif.key_flag[0]) begin npulse++; if (first < 0) first = cyc; end
            if (prev && !kif.key_level[0] && fall < 0) fall = cyc;
            prev = kif.key_level[0];
        end
        checks++;
        if (first !== e + 11) begin failures++; $display("FAIL clean_press_latency got=%0d required=%0d", first - e, 11); end
        checks++;
        if (npulse !== 1) begin failures++; $display("FAIL clean_press_count got=%0d required=1", npulse); end
        checks++;
        if (fall !== e + 40) begin failures++; $display("FAIL release_latency got=%0d required=%0d", fall - e - 30, 10); end
    endtask

    task automatic test_bounce();
        int e = 0, first = -1, npulse = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (c == 7) e = cyc + 1;
            kif.key = ((c < 5) || (c >= 7 && c < 27)) ? 2'b01 : 2'b11;
            @(negedge clk);
            checks++;
            if (kif.key_flag !== exp_flag || kif.key_level !== exp_level) begin
                failures++;
                $display("FAIL bounce_model cyc=%0d flag=%b/%b level=%b/%b", cyc, kif.key_flag, exp_flag, kif.key_level, exp_level);
            end
            if (kif.key_flag[1]) begin npulse++; if (first < 0) first = cyc; end
        end
        checks++;
        if (npulse !== 1) begin failures++; $display("FAIL bounce_count got=%0d required=1", npulse); end
        checks++;
        if (first !== e + 11) begin failures++; $display("FAIL bounce_latency got=%0d required=11", first - e); end
    endtask

    task automatic test_back_to_back();
        int e = 0;
        logic [1:0] seen [int];
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (c == 0) e = cyc + 1;
            kif.key = (c < 20) ? 2'b00 : 2'b11;
            @(negedge clk);
            seen[cyc] = kif.key_flag;
            checks++;
            if (kif.key_flag === 2'b11 || kif.key_flag !== exp_flag) begin
                failures++;
                $display("FAIL both_model cyc=%0d flag=%b required=%b", cyc, kif.key_flag, exp_flag);
            end
        end
        checks++;
        if (seen[e + 11] !== 2'b01) begin failures++; $display("FAIL both_first got=%b required=01", seen[e + 11]); end
        checks++;
        if (seen[e + 12] !== 2'b10) begin failures++; $display("FAIL both_second got=%b required=10", seen[e + 12]); end
    endtask

    task automatic test_reset_mid();
        int rr = 0, first = -1, npulse = 0;
        @(posedge clk); #1 kif.key = 2'b10;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (kif.key_flag !== 2'b00 || kif.key_level !== 2'b00) begin
                failures++;
                $display("FAIL reset_mid_hold flag=%b level=%b required 00/00", kif.key_flag, kif.key_level);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1; rr = cyc + 1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            kif.key = (c < 25) ? 2'b10 : 2'b11;
            @(negedge clk);
            checks++;
            if (kif.key_flag !== exp_flag || kif.key_level !== exp_level) begin
                failures++;
                $display("FAIL reset_mid_model cyc=%0d flag=%b/%b level=%b/%b", cyc, kif.key_flag, exp_flag, kif.key_level, exp_level);
            end
            if (kif.key_flag[0]) begin npulse++; if (first < 0) first = cyc; end
        end
        checks++;
        if (npulse !== 1 || first !== rr + 11) begin
            failures++;
            $display("FAIL reset_mid_pulse count=%0d at=%0d required 1 at %0d", npulse, first - rr, 11);
        end
    endtask

    task automatic test_glitch();
        int npulse = 0, drops = 0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            kif.key = ((c < 25) || (c >= 28 && c < 48)) ? 2'b10 : 2'b11;
            @(negedge clk);
            checks++;
            if (kif.key_flag !== exp_flag || kif.key_level !== exp_level) begin
                failures++;
                $display("FAIL glitch_model cyc=%0d flag=%b/%b level=%b/%b", cyc, kif.key_flag, exp_flag, kif.key_level, exp_level);
            end
            if (kif.key_flag[0]) npulse++;
            if (c > 12 && c < 48 && !kif.key_level[0]) drops++;
        end
        checks++;
        if (npulse !== 1) begin failures++; $display("FAIL glitch_count got=%0d required=1", npulse); end
        checks++;
        if (drops !== 0) begin failures++; $display("FAIL glitch_level low_cycles=%0d required=0", drops); end
    endtask

    task automatic test_repeat();
        int e = 0;
        int got [$];
        int want [$];
`ifdef KEY_REPEAT_EN
        want = '{11, 51, 67, 83, 99};
`else
        want = '{11};
`endif
        for (int c = 0; c < 130; c++) begin
            @(posedge clk); #1;
            if (c == 0) e = cyc + 1;
            kif.key = (c < 100) ? 2'b10 : 2'b11;
            @(negedge clk);
            checks++;
            if (kif.key_flag !== exp_flag || kif.key_level !== exp_level) begin
                failures++;
                $display("FAIL repeat_model cyc=%0d flag=%b/%b level=%b/%b", cyc, kif.key_flag, exp_flag, kif.key_level, exp_level);
            end
            if (kif.key_flag[0]) got.push_back(cyc - e);
        end
        checks++;
        if (got.size() !== want.size()) begin
            failures++;
            $display("FAIL repeat_count got=%0d required=%0d", got.size(), want.size());
        end else begin
            foreach (want[i]) begin
                checks++;
                if (got[i] !== want[i]) begin failures++; $display("FAIL repeat_time[%0d] got=%0d required=%0d", i, got[i], want[i]); end
            end
        end
    endtask

    task automatic test_random();
        int left [2] = '{0, 0};
        logic [1:0] k = 2'b11;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (left[i] == 0) begin
                    k[i] = ~k[i];
                    left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(D + 2, 70));
                end
                left[i]--;
            end
            kif.key = k;
            if (c == 700) rst_n = 1'b0;
            if (c == 703) rst_n = 1'b1;
            @(negedge clk);
            checks++;
            if (kif.key_flag !== exp_flag || kif.key_level !== exp_level) begin
                failures++;
                $display("FAIL random_model cyc=%0d flag=%b/%b level=%b/%b", cyc, kif.key_flag, exp_flag, kif.key_level, exp_level);
            end
        end
        @(posedge clk); #1 kif.key = 2'b11;
        repeat (20) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_back_to_back();
        test_reset_mid();
        test_glitch();
        test_repeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
